// File: rtl/cnt_sched_pkg.sv
// Shared types and helpers for the cnt_dwn scheduler: FSM state encoding,
// default counter width and index-width helper.
package cnt_sched_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      RUN,
      DONE
   } state_t;

   localparam int CNT_W_DEF = 4;

   // Width needed to index n items; never below one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cnt_dwn_sched_if.sv
// Requester-side and cnt_dwn-side signals of the scheduler.
// The master modport is the scheduler; slave is the requesters plus cnt_dwn.
interface cnt_dwn_sched_if #(
   parameter int NREQ  = 4,
   parameter int CNT_W = cnt_sched_pkg::CNT_W_DEF
);
   import cnt_sched_pkg::*;

   localparam int OWN_W = idx_w(NREQ);

   logic [NREQ-1:0]       req;
   logic [NREQ*CNT_W-1:0] req_val;
   logic [NREQ-1:0]       cancel;
   logic [NREQ-1:0]       gnt;
   logic [NREQ-1:0]       done;
   logic                  busy;
   logic [OWN_W-1:0]      owner;
   logic [CNT_W-1:0]      cnt_in;
   logic                  cnt_latch;
   logic                  cnt_dec;
   logic                  cnt_zero;

   modport master (
      input  req, req_val, cancel, cnt_zero,
      output gnt, done, busy, owner, cnt_in, cnt_latch, cnt_dec
   );

   modport slave (
      output req, req_val, cancel, cnt_zero,
      input  gnt, done, busy, owner, cnt_in, cnt_latch, cnt_dec
   );

endinterface

// File: rtl/cnt_dwn.sv
// Shared 4-bit down-counter: latch loads, dec decrements, zero is combinational.
// No reset; the scheduler always loads it before use.
module cnt_dwn #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic [CNT_W-1:0] in,
   input  logic             latch,
   input  logic             dec,
   output logic             zero
);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk) begin
      if (latch) begin
         count <= in;
      end else if (dec) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/cnt_dwn_sched_rr_arb.sv
// Combinational round-robin arbiter: first set request at or after ptr,
// wrapping, returned both one-hot and as an index.
module rr_arb #(
   parameter int NREQ  = 4,
   parameter int OWN_W = 2
) (
   input  logic [NREQ-1:0]  req,
   input  logic [OWN_W-1:0] ptr,
   output logic [NREQ-1:0]  gnt,
   output logic [OWN_W-1:0] idx,
   output logic             any
);

   int i;

   always_comb begin
      gnt = '0;
      idx = '0;
      any = 1'b0;
      i   = 0;
      for (int k = 0; k < NREQ; k++) begin
         i = (int'(ptr) + k) % NREQ;
         if (!any && req[i]) begin
            any    = 1'b1;
            gnt[i] = 1'b1;
            idx    = OWN_W'(i);
         end
      end
   end

endmodule

// File: rtl/cnt_dwn_sched.sv
// Time-shares one cnt_dwn instance between NREQ requesters as a one-shot delay
// timer: round-robin grant, load, prescaled decrement, done pulse on zero.
module cnt_dwn_sched
   import cnt_sched_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int CNT_W = CNT_W_DEF,
   parameter int PRESC = 1
) (
   input  logic             clk,
   input  logic             rst,
   cnt_dwn_sched_if.master  bus
);

   localparam int                OWN_W    = idx_w(NREQ);
   localparam int                PRE_W    = idx_w(PRESC);
   localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(PRESC - 1);
   localparam logic [OWN_W-1:0]  OWN_LAST = OWN_W'(NREQ - 1);

   state_t            state, state_n;
   logic [OWN_W-1:0]  ptr, ptr_n;
   logic [OWN_W-1:0]  owner_r, owner_inc;
   logic [NREQ-1:0]   own_oh;
   logic [CNT_W-1:0]  val_r;
   logic [PRE_W-1:0]  pres_cnt;
   logic [NREQ-1:0]   arb_gnt;
   logic [OWN_W-1:0]  arb_idx;
   logic              arb_any;
   logic              own_cancel;

   rr_arb #(
      .NREQ  (NREQ),
      .OWN_W (OWN_W)
   ) u_arb (
      .req (bus.req),
      .ptr (ptr),
      .gnt (arb_gnt),
      .idx (arb_idx),
      .any (arb_any)
   );

   assign owner_inc  = (owner_r == OWN_LAST) ? '0 : owner_r + 1'b1;
   assign own_cancel = |(bus.cancel & own_oh);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         ptr      <= '0;
         owner_r  <= '0;
         own_oh   <= '0;
         pres_cnt <= '0;
      end else begin
         state <= state_n;
         ptr   <= ptr_n;
         if (state == IDLE && arb_any) begin
            owner_r <= arb_idx;
            own_oh  <= arb_gnt;
         end
         // Prescaler only runs in RUN, so every job starts at phase 0.
         if (state == RUN) begin
            pres_cnt <= (pres_cnt == PRE_LAST) ? '0 : pres_cnt + 1'b1;
         end else begin
            pres_cnt <= '0;
         end
      end
   end

   // Load value is only ever observed in LOAD, so it needs no reset.
   always_ff @(posedge clk) begin
      if (state == IDLE && arb_any) begin
         val_r <= bus.req_val[int'(arb_idx)*CNT_W +: CNT_W];
      end
   end

   always_comb begin
      state_n       = state;
      ptr_n         = ptr;
      bus.gnt       = '0;
      bus.done      = '0;
      bus.cnt_in    = '0;
      bus.cnt_latch = 1'b0;
      bus.cnt_dec   = 1'b0;
      case (state)
         IDLE: begin
            if (arb_any) begin
               state_n = LOAD;
            end
         end
         LOAD: begin
            bus.gnt       = own_oh;
            bus.cnt_latch = 1'b1;
            bus.cnt_in    = val_r;
            state_n       = RUN;
         end
         RUN: begin
            // Gating on zero keeps the counter from wrapping past 0.
            bus.cnt_dec = (pres_cnt == PRE_LAST) && !bus.cnt_zero;
            if (own_cancel) begin
               state_n = IDLE;
               ptr_n   = owner_inc;
            end else if (bus.cnt_zero) begin
               state_n = DONE;
            end
         end
         DONE: begin
            bus.done = own_oh;
            ptr_n    = owner_inc;
            state_n  = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   assign bus.busy  = (state != IDLE);
   assign bus.owner = owner_r;

endmodule
